// File: rtl/fib_req_arbiter.sv
// Round-robin arbiter in front of one shared iterative Fibonacci datapath.
// Each accepted request runs n add/shift steps and returns F(n) mod 2^WIDTH with a sticky overflow flag.
module fib_req_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int NW    = 5,
   parameter int IDW   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*NW-1:0]   req_n,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [WIDTH-1:0]     rsp_fib,
   output logic                 rsp_ovf,
   input  logic                 rsp_ready,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, COMPUTE, RESPOND} state_t;

   state_t           state, state_next;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   id;
   logic [NW-1:0]    count;
   logic [WIDTH-1:0] a, b;
   logic             oa, ob;

   logic             grant_found;
   logic [IDW-1:0]   grant_id;
   logic [IDW-1:0]   cand;
   logic [NW-1:0]    sel_n;
   logic [WIDTH:0]   sum;

   // Search from rr_ptr upward (wrapping) for the first pending requester.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'((int'(rr_ptr) + k) % NREQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
   end

   always_comb begin
      sel_n = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant_id == IDW'(k)) sel_n = req_n[k*NW +: NW];
      end
   end

   assign req_ready = (state == IDLE && grant_found) ? (NREQ'(1) << grant_id) : '0;
   assign sum       = {1'b0, a} + {1'b0, b};
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_found) state_next = COMPUTE;
         COMPUTE: if (count == '0) state_next = RESPOND;
         RESPOND: if (rsp_ready)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // a/b walk the sequence; oa/ob track whether the true F value behind each has wrapped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         id        <= '0;
         count     <= '0;
         a         <= '0;
         b         <= WIDTH'(1);
         oa        <= 1'b0;
         ob        <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_fib   <= '0;
         rsp_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  id    <= grant_id;
                  count <= sel_n;
                  a     <= '0;
                  b     <= WIDTH'(1);
                  oa    <= 1'b0;
                  ob    <= 1'b0;
               end
            end
            COMPUTE: begin
               if (count != '0) begin
                  a     <= b;
                  b     <= sum[WIDTH-1:0];
                  oa    <= ob;
                  ob    <= ob | oa | sum[WIDTH];
                  count <= count - NW'(1);
               end else begin
                  rsp_fib   <= a;
                  rsp_ovf   <= oa;
                  rsp_id    <= id;
                  rsp_valid <= 1'b1;
               end
            end
            RESPOND: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rr_ptr    <= (id == IDW'(NREQ-1)) ? '0 : id + IDW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fib_req_arbiter.sv
// Directed bench for fib_req_arbiter: boundary indices, overflow, round-robin order,
// back-pressure and mid-compute reset, each checked against hand-computed values.
module tb_fib_req_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [19:0] req_n;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_fib;
   logic        rsp_ovf;
   logic        rsp_ready;
   logic        busy;

   int checks = 0;
   int errors = 0;

   fib_req_arbiter #(.NREQ(4), .WIDTH(8), .NW(5), .IDW(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_fib(rsp_fib), .rsp_ovf(rsp_ovf),
      .rsp_ready(rsp_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Clock until rsp_valid rises, bounded so a stuck DUT shows up as a latency failure.
   task automatic wait_rsp(output int edges);
      edges = 0;
      while (edges < 100) begin
         tick();
         edges++;
         if (rsp_valid) break;
      end
   endtask

   task automatic apply_stimulus(input int idx, input int n, input int exp_fib, input int exp_ovf,
                                 input int exp_lat);
      int lat;
      req_valid      = 4'b0;
      req_valid[idx] = 1'b1;
      req_n[idx*5 +: 5] = 5'(n);
      rsp_ready      = 1'b1;
      #1;
      check_output($sformatf("req_ready n=%0d", n), 32'(req_ready), 32'(1 << idx));
      tick();
      req_valid = 4'b0;
      check_output($sformatf("busy n=%0d", n), 32'(busy), 32'd1);
      wait_rsp(lat);
      check_output($sformatf("latency n=%0d", n), 32'(lat), 32'(exp_lat));
      check_output($sformatf("rsp_id n=%0d", n), 32'(rsp_id), 32'(idx));
      check_output($sformatf("rsp_fib n=%0d", n), 32'(rsp_fib), 32'(exp_fib));
      check_output($sformatf("rsp_ovf n=%0d", n), 32'(rsp_ovf), 32'(exp_ovf));
      tick();
      check_output($sformatf("rsp_valid_lo n=%0d", n), 32'(rsp_valid), 32'd0);
      check_output($sformatf("idle n=%0d", n), 32'(busy), 32'd0);
   endtask

   initial begin
      int lat;
      int exp_id  [5] = '{0, 1, 2, 3, 0};
      int exp_fib [5] = '{2, 3, 5, 8, 2};

      rst = 1'b1;
      req_valid = 4'b0;
      req_n = '0;
      rsp_ready = 1'b0;
      repeat (2) tick();
      check_output("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("reset rsp_id", 32'(rsp_id), 32'd0);
      check_output("reset rsp_fib", 32'(rsp_fib), 32'd0);
      check_output("reset rsp_ovf", 32'(rsp_ovf), 32'd0);
      check_output("reset busy", 32'(busy), 32'd0);
      check_output("reset req_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      tick();

      apply_stimulus(1, 10, 55, 0, 11);
      apply_stimulus(0, 0, 0, 0, 1);
      apply_stimulus(2, 1, 1, 0, 2);
      apply_stimulus(0, 13, 233, 0, 14);
      apply_stimulus(1, 14, 121, 1, 15);
      apply_stimulus(3, 20, 109, 1, 21);

      // rr_ptr is now 0; all four requesters compete.
      req_n = {5'd6, 5'd5, 5'd4, 5'd3};
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_output($sformatf("rr req_ready %0d", i), 32'(req_ready), 32'(1 << exp_id[i]));
         tick();
         if (i == 4) req_valid = 4'b0;
         wait_rsp(lat);
         check_output($sformatf("rr rsp_id %0d", i), 32'(rsp_id), 32'(exp_id[i]));
         check_output($sformatf("rr rsp_fib %0d", i), 32'(rsp_fib), 32'(exp_fib[i]));
         tick();
      end

      // rr_ptr is now 1: requester 2 wins; then stall the response for 7 cycles.
      rsp_ready = 1'b0;
      req_valid = 4'b0100;
      req_n[10 +: 5] = 5'd5;
      #1;
      check_output("bp req_ready", 32'(req_ready), 32'b0100);
      tick();
      req_valid = 4'b0001;
      wait_rsp(lat);
      check_output("bp latency", 32'(lat), 32'd6);
      for (int i = 0; i < 7; i++) begin
         tick();
         check_output($sformatf("bp rsp_valid %0d", i), 32'(rsp_valid), 32'd1);
         check_output($sformatf("bp rsp_fib %0d", i), 32'(rsp_fib), 32'd5);
         check_output($sformatf("bp rsp_id %0d", i), 32'(rsp_id), 32'd2);
         check_output($sformatf("bp req_ready %0d", i), 32'(req_ready), 32'd0);
         check_output($sformatf("bp busy %0d", i), 32'(busy), 32'd1);
      end
      rsp_ready = 1'b1;
      tick();
      check_output("bp released rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("bp released busy", 32'(busy), 32'd0);
      check_output("bp next grant", 32'(req_ready), 32'b0001);
      req_valid = 4'b0;

      // rr_ptr is now 3: start n=20 on requester 3, reset mid-compute.
      req_valid = 4'b1000;
      req_n[15 +: 5] = 5'd20;
      tick();
      req_valid = 4'b0;
      repeat (5) tick();
      check_output("pre-reset busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_output("async rst busy", 32'(busy), 32'd0);
      check_output("async rst rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("async rst rsp_fib", 32'(rsp_fib), 32'd0);
      check_output("async rst rsp_id", 32'(rsp_id), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check_output("post-reset rsp_valid", 32'(rsp_valid), 32'd0);

      // Both 2 and 3 pending; a reset pointer of 0 must pick 2.
      req_valid = 4'b1100;
      req_n[10 +: 5] = 5'd6;
      #1;
      check_output("post-reset grant", 32'(req_ready), 32'b0100);
      tick();
      req_valid = 4'b0;
      wait_rsp(lat);
      check_output("post-reset latency", 32'(lat), 32'd7);
      check_output("post-reset rsp_id", 32'(rsp_id), 32'd2);
      check_output("post-reset rsp_fib", 32'(rsp_fib), 32'd8);
      check_output("post-reset rsp_ovf", 32'(rsp_ovf), 32'd0);
      tick();
      check_output("post-reset done", 32'(rsp_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fib_req_arbiter.md
Name: fib_req_arbiter

Overview:
Shared iterative Fibonacci engine with round-robin arbitration across NREQ requesters. Each requester asks for term F(n). The block grants one request at a time and computes F(n) by n add/shift iterations on internal registers a/b. It returns the term tagged with the requester id, plus a modular-overflow flag. It sits between client blocks and the single Fibonacci adder datapath, so the adder is not replicated per client.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, result width; arithmetic is modulo 2^WIDTH
NW, 5, width of each requested index n (n in 0..2^NW-1)
IDW, 2, width of rsp_id; must equal ceil(log2(NREQ))

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  NREQ  per-requester request valid; bit i belongs to requester i
req_n  input  NREQ*NW  requested index; slice [i*NW +: NW] belongs to requester i
req_ready  output  NREQ  one-hot grant/accept; combinational
rsp_valid  output  1  response valid, registered
rsp_id  output  IDW  index of the served requester
rsp_fib  output  WIDTH  F(n) mod 2^WIDTH
rsp_ovf  output  1  1 if the true F(n) >= 2^WIDTH
rsp_ready  input  1  consumer accepts the response
busy  output  1  high in COMPUTE and RESPOND

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_fib=0, rsp_ovf=0, busy=0.
  - Internal a=0, b=1, count=0, ovf flags=0.
- Reset mid-operation aborts the in-flight request with no response. After rst falls, the block behaves exactly as after power-on.
- FSM states: IDLE, COMPUTE, RESPOND.
- IDLE:
  - Grant = the first requester with req_valid=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready is that requester's bit, and only in IDLE. All bits are 0 in other states or when no request is present.
  - Accept = req_valid[g] & req_ready[g] at a clock edge. On accept, latch id=g and count=req_n[g].
  - Also on accept: a=0, b=1, oa=0 (overflow of a), ob=0 (overflow of b). Go to COMPUTE.
- COMPUTE, each edge:
  - If count!=0: {c,s}=a+b (WIDTH+1 bits), a<=b, b<=s, oa<=ob, ob<=ob|oa|c, count<=count-1.
  - If count==0: rsp_fib<=a, rsp_ovf<=oa, rsp_id<=id, rsp_valid<=1, go to RESPOND.
- Latency: rsp_valid rises exactly n+1 clock edges after the accept edge. n=0 gives 1 edge.
- RESPOND:
  - rsp_valid, rsp_id, rsp_fib and rsp_ovf are held stable until rsp_ready=1 at an edge.
  - On that edge: rsp_valid<=0, rr_ptr<=(id+1) mod NREQ, go to IDLE.
  - Back-pressure of any length is legal; no data changes while stalled.
- Throughput:
  - Minimum request-to-request spacing is n+3 edges: accept, n+1 compute edges, response edge, then one IDLE edge before the next accept.
  - The next accept can occur on the edge after the response handshake.
- Requesters may drop or change req_valid/req_n while not granted. Values are sampled only on the accept edge.
- A requester that holds req_valid continuously is served at most once per NREQ grants when others are also requesting (round-robin fairness).
- Sticky overflow: once any intermediate term wraps, every later term is flagged. rsp_fib is still the mod-2^WIDTH value.
- busy = (state != IDLE).

Test Plan:
- Reset, then requester 1 asks n=10 with rsp_ready=1 -> req_ready=4'b0010 for one accept edge; rsp_valid rises 11 edges later with rsp_id=1, rsp_fib=55, rsp_ovf=0.
- Boundary indices n=0 and n=1 -> rsp_fib=0 then 1, ovf=0, latency 1 and 2 edges; n=13 -> 233, ovf=0.
- Overflow: n=14 -> rsp_fib=121 (377 mod 256), rsp_ovf=1; n=20 -> rsp_fib=6765 mod 256=109, rsp_ovf=1.
- Round-robin: all four requesters hold req_valid with n=3,4,5,6 -> service order ids 0,1,2,3,0; results 2,3,5,8,2; no id is served twice before all have been served.
- Back-pressure: rsp_ready=0 for 7 cycles in RESPOND -> outputs stable, req_ready all 0, busy=1; the handshake on cycle 8 returns the FSM to IDLE.
- Reset pulse in COMPUTE (n=20, asserted after 5 edges) -> all outputs 0 immediately; after release, a fresh request from requester 2, n=6, returns 8, id=2, and rr_ptr starts from 0.
